// File: rtl/sram_controller.sv
// 32-bit load/store front end for a 16-bit asynchronous SRAM: each word access is split
// into a low and a high half-word phase, each held for WAIT_CYCLES clock cycles.
module sram_controller #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic [1:0]  dbg_state
);

    // Handshake: a request (rd_en|wr_en) is accepted only while in IDLE, and ready drops in
    // that same cycle; ready rises again for the single DONE cycle that ends the access.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LO   = 2'd1;
    localparam logic [1:0] HI   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [16:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] read_data_q, read_data_d;
    logic [17:0] sram_addr_q, sram_addr_d;
    logic [15:0] dq_out_q, dq_out_d;
    logic        dq_oe_q, dq_oe_d;
    logic        we_n_q, we_n_d;
    logic        oe_n_q, oe_n_d;

    logic req;
    logic last_cycle;
    logic unused_addr_bits;

    assign req              = rd_en | wr_en;
    assign last_cycle       = (cnt_q == CNT_LAST);
    assign unused_addr_bits = ^{address[31:19], address[1:0]};

    // Pin values are registered from the next state, so they are glitch-free and line up
    // exactly with the LO/HI phases they belong to.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        is_wr_d     = is_wr_q;
        read_data_d = read_data_q;
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        dq_oe_d     = dq_oe_q;
        we_n_d      = we_n_q;
        oe_n_d      = oe_n_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d     = LO;
                    cnt_d       = 4'd0;
                    addr_d      = address[18:2];
                    data_d      = write_data;
                    is_wr_d     = wr_en;
                    sram_addr_d = {address[18:2], 1'b0};
                    we_n_d      = ~wr_en;
                    oe_n_d      = wr_en;
                    dq_oe_d     = wr_en;
                    if (wr_en) begin
                        dq_out_d = write_data[15:0];
                    end
                end
            end
            LO: begin
                if (last_cycle) begin
                    state_d     = HI;
                    cnt_d       = 4'd0;
                    sram_addr_d = {addr_q, 1'b1};
                    if (is_wr_q) begin
                        dq_out_d = data_q[31:16];
                    end else begin
                        read_data_d[15:0] = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HI: begin
                if (last_cycle) begin
                    state_d = DONE;
                    cnt_d   = 4'd0;
                    we_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    dq_oe_d = 1'b0;
                    if (!is_wr_q) begin
                        read_data_d[31:16] = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 17'd0;
            data_q      <= 32'd0;
            is_wr_q     <= 1'b0;
            read_data_q <= 32'd0;
            sram_addr_q <= 18'd0;
            dq_out_q    <= 16'd0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            is_wr_q     <= is_wr_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
        end
    end

    assign ready       = (state_q == DONE) | ((state_q == IDLE) & ~req);
    assign read_data   = read_data_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;
    assign sram_oe_n   = oe_n_q;
    assign dbg_state   = state_q;

endmodule
